// File: rtl/du_report_tx_pkg.sv
// Shared definitions for the debug-unit report transmitter.
// Holds FSM state encodings, word-source encoding, UART frame levels and
// helpers that map a dump word index to its source.
package du_report_tx_pkg;

   // Top-level dump FSM
   localparam int unsigned NB_STATE = 3;
   localparam logic [NB_STATE-1:0] ST_IDLE  = 3'd0;
   localparam logic [NB_STATE-1:0] ST_LOAD  = 3'd1;
   localparam logic [NB_STATE-1:0] ST_FETCH = 3'd2;
   localparam logic [NB_STATE-1:0] ST_SEND  = 3'd3;
   localparam logic [NB_STATE-1:0] ST_WAIT  = 3'd4;
   localparam logic [NB_STATE-1:0] ST_DONE  = 3'd5;

   // Where a dump word comes from
   localparam int unsigned NB_SRC = 2;
   localparam logic [NB_SRC-1:0] SRC_PC     = 2'd0;
   localparam logic [NB_SRC-1:0] SRC_CYCLES = 2'd1;
   localparam logic [NB_SRC-1:0] SRC_REG    = 2'd2;
   localparam logic [NB_SRC-1:0] SRC_MEM    = 2'd3;

   // PC and cycle count precede the register file in the stream
   localparam int unsigned N_FIXED_WORDS = 2;

   // Byte serializer FSM and line levels
   localparam int unsigned NB_UART_STATE = 2;
   localparam logic [NB_UART_STATE-1:0] UART_IDLE  = 2'd0;
   localparam logic [NB_UART_STATE-1:0] UART_START = 2'd1;
   localparam logic [NB_UART_STATE-1:0] UART_DATA  = 2'd2;
   localparam logic [NB_UART_STATE-1:0] UART_STOP  = 2'd3;
   localparam logic UART_START_LEVEL = 1'b0;
   localparam logic UART_STOP_LEVEL  = 1'b1;

   // Number of words in one complete dump
   function automatic int unsigned total_words(input int unsigned n_regs,
                                               input int unsigned n_mem);
      return N_FIXED_WORDS + n_regs + n_mem;
   endfunction

   // Source of the word at position idx in the dump
   function automatic logic [NB_SRC-1:0] word_src(input int unsigned idx,
                                                  input int unsigned n_regs);
      if (idx == 0)                      return SRC_PC;
      if (idx == 1)                      return SRC_CYCLES;
      if (idx < N_FIXED_WORDS + n_regs)  return SRC_REG;
      return SRC_MEM;
   endfunction

endpackage

// File: rtl/du_uart_tx.sv
// Bit-level 8N1 serializer.
// Ports: i_clk, i_reset (async active-low), i_tick (16x baud enable),
//        i_tx_start (byte request pulse), i_data (byte),
//        o_tx (serial line, idle high), o_tx_done (pulse on the tick ending the stop bit).
module du_uart_tx
   import du_report_tx_pkg::*;
#(
   parameter int unsigned NB_BYTE = 8,
   parameter int unsigned SB_TICK = 16
)
(
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_tick,
   input  logic               i_tx_start,
   input  logic [NB_BYTE-1:0] i_data,
   output logic               o_tx,
   output logic               o_tx_done
);

   localparam int unsigned NB_TICK = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
   localparam int unsigned NB_BIT  = (NB_BYTE > 1) ? $clog2(NB_BYTE) : 1;
   localparam logic [NB_TICK-1:0] TICK_LAST = NB_TICK'(SB_TICK - 1);
   localparam logic [NB_BIT-1:0]  BIT_LAST  = NB_BIT'(NB_BYTE - 1);

   logic [NB_UART_STATE-1:0] state, state_nxt;
   logic [NB_TICK-1:0]       tick_cnt, tick_cnt_nxt;
   logic [NB_BIT-1:0]        bit_cnt, bit_cnt_nxt;
   logic [NB_BYTE-1:0]       shreg, shreg_nxt;
   logic                     pend, pend_nxt;
   logic                     tx_nxt, tx_done_nxt;
   logic                     bit_end;

   // State and output registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state     <= UART_IDLE;
         tick_cnt  <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         pend      <= 1'b0;
         o_tx      <= UART_STOP_LEVEL;
         o_tx_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         tick_cnt  <= tick_cnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shreg     <= shreg_nxt;
         pend      <= pend_nxt;
         o_tx      <= tx_nxt;
         o_tx_done <= tx_done_nxt;
      end
   end

   // Next-state logic; everything advances only on a tick, so no tick means a stall
   always_comb begin
      state_nxt    = state;
      tick_cnt_nxt = tick_cnt;
      bit_cnt_nxt  = bit_cnt;
      shreg_nxt    = shreg;
      pend_nxt     = pend;
      tx_nxt       = o_tx;
      tx_done_nxt  = 1'b0;
      bit_end      = i_tick && (tick_cnt == TICK_LAST);

      if ((state != UART_IDLE) && i_tick)
         tick_cnt_nxt = bit_end ? '0 : tick_cnt + NB_TICK'(1);

      case (state)
         UART_IDLE: begin
            // A request waits in pend until the next tick opens the start bit
            if (i_tx_start) begin
               shreg_nxt = i_data;
               pend_nxt  = 1'b1;
            end
            if ((i_tx_start || pend) && i_tick) begin
               state_nxt    = UART_START;
               tx_nxt       = UART_START_LEVEL;
               tick_cnt_nxt = '0;
               pend_nxt     = 1'b0;
            end
         end
         UART_START: begin
            if (bit_end) begin
               state_nxt   = UART_DATA;
               bit_cnt_nxt = '0;
               tx_nxt      = shreg[0];
            end
         end
         UART_DATA: begin
            if (bit_end) begin
               if (bit_cnt == BIT_LAST) begin
                  state_nxt = UART_STOP;
                  tx_nxt    = UART_STOP_LEVEL;
               end else begin
                  bit_cnt_nxt = bit_cnt + NB_BIT'(1);
                  shreg_nxt   = shreg >> 1;
                  tx_nxt      = shreg[1];
               end
            end
         end
         UART_STOP: begin
            if (bit_end) begin
               state_nxt   = UART_IDLE;
               tx_done_nxt = 1'b1;
            end
         end
         default: state_nxt = UART_IDLE;
      endcase
   end

endmodule

// File: rtl/du_report_tx.sv
// Debug-unit report transmitter: on i_start, snapshots PC and cycle count,
// then streams PC, CYCLES, R0..Rn, M0..Mm as MSB-first bytes over 8N1 UART.
// Ports: i_clk, i_reset (async active-low), i_tick (16x baud enable),
//        i_start (dump request), i_pc/i_cycles (snapshot sources),
//        o_reg_addr/i_reg_data and o_mem_addr/i_mem_data (1-cycle sync reads),
//        o_tx (serial line), o_busy (dump in progress), o_done (completion pulse).
module du_report_tx
   import du_report_tx_pkg::*;
#(
   parameter int unsigned NB_DATA     = 32,
   parameter int unsigned NB_BYTE     = 8,
   parameter int unsigned NB_REGISTER = 5,
   parameter int unsigned N_REGISTERS = 32,
   parameter int unsigned NB_MEM_ADDR = 4,
   parameter int unsigned N_MEM_WORDS = 16,
   parameter int unsigned SB_TICK     = 16
)
(
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic                   i_tick,
   input  logic                   i_start,
   input  logic [NB_DATA-1:0]     i_pc,
   input  logic [NB_DATA-1:0]     i_cycles,
   output logic [NB_REGISTER-1:0] o_reg_addr,
   input  logic [NB_DATA-1:0]     i_reg_data,
   output logic [NB_MEM_ADDR-1:0] o_mem_addr,
   input  logic [NB_DATA-1:0]     i_mem_data,
   output logic                   o_tx,
   output logic                   o_busy,
   output logic                   o_done
);

   localparam int unsigned N_BYTES     = NB_DATA / NB_BYTE;
   localparam int unsigned NB_BYTE_IDX = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int unsigned N_WORDS     = total_words(N_REGISTERS, N_MEM_WORDS);
   localparam int unsigned NB_WORD_IDX = $clog2(N_WORDS + 1);
   localparam int unsigned MEM_BASE    = N_FIXED_WORDS + N_REGISTERS;

   logic [NB_STATE-1:0]    state, state_nxt;
   logic [NB_WORD_IDX-1:0] word_idx, word_idx_nxt;
   logic [NB_BYTE_IDX-1:0] byte_idx, byte_idx_nxt;
   logic [NB_DATA-1:0]     word_sr, word_sr_nxt;
   logic [NB_DATA-1:0]     pc_snap, pc_snap_nxt;
   logic [NB_DATA-1:0]     cyc_snap, cyc_snap_nxt;
   logic [NB_REGISTER-1:0] reg_addr_nxt;
   logic [NB_MEM_ADDR-1:0] mem_addr_nxt;
   logic                   busy_nxt, done_nxt;
   logic [NB_SRC-1:0]      src, load_src;
   logic                   tx_start_c;
   logic [NB_BYTE-1:0]     tx_byte_c;
   logic                   tx_done;

   assign tx_start_c = (state == ST_SEND);
   assign tx_byte_c  = word_sr[NB_DATA-1 -: NB_BYTE];

   du_uart_tx #(
      .NB_BYTE (NB_BYTE),
      .SB_TICK (SB_TICK)
   ) u_uart_tx (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_tick     (i_tick),
      .i_tx_start (tx_start_c),
      .i_data     (tx_byte_c),
      .o_tx       (o_tx),
      .o_tx_done  (tx_done)
   );

   // State and output registers
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state      <= ST_IDLE;
         word_idx   <= '0;
         byte_idx   <= '0;
         word_sr    <= '0;
         pc_snap    <= '0;
         cyc_snap   <= '0;
         o_reg_addr <= '0;
         o_mem_addr <= '0;
         o_busy     <= 1'b0;
         o_done     <= 1'b0;
      end else begin
         state      <= state_nxt;
         word_idx   <= word_idx_nxt;
         byte_idx   <= byte_idx_nxt;
         word_sr    <= word_sr_nxt;
         pc_snap    <= pc_snap_nxt;
         cyc_snap   <= cyc_snap_nxt;
         o_reg_addr <= reg_addr_nxt;
         o_mem_addr <= mem_addr_nxt;
         o_busy     <= busy_nxt;
         o_done     <= done_nxt;
      end
   end

   // Dump sequencing and registered-output next values
   always_comb begin
      state_nxt    = state;
      word_idx_nxt = word_idx;
      byte_idx_nxt = byte_idx;
      word_sr_nxt  = word_sr;
      pc_snap_nxt  = pc_snap;
      cyc_snap_nxt = cyc_snap;
      reg_addr_nxt = o_reg_addr;
      mem_addr_nxt = o_mem_addr;
      src          = word_src(32'(word_idx), N_REGISTERS);

      case (state)
         ST_IDLE: begin
            if (i_start) begin
               pc_snap_nxt  = i_pc;
               cyc_snap_nxt = i_cycles;
               word_idx_nxt = '0;
               byte_idx_nxt = '0;
               state_nxt    = ST_LOAD;
            end
         end
         ST_LOAD: begin
            case (src)
               SRC_PC: begin
                  word_sr_nxt = pc_snap;
                  state_nxt   = ST_SEND;
               end
               SRC_CYCLES: begin
                  word_sr_nxt = cyc_snap;
                  state_nxt   = ST_SEND;
               end
               default: state_nxt = ST_FETCH;
            endcase
         end
         ST_FETCH: begin
            word_sr_nxt = (src == SRC_REG) ? i_reg_data : i_mem_data;
            state_nxt   = ST_SEND;
         end
         ST_SEND: state_nxt = ST_WAIT;
         ST_WAIT: begin
            if (tx_done) begin
               word_sr_nxt = word_sr << NB_BYTE;
               if (byte_idx == NB_BYTE_IDX'(N_BYTES - 1)) begin
                  byte_idx_nxt = '0;
                  word_idx_nxt = word_idx + NB_WORD_IDX'(1);
                  state_nxt    = (word_idx_nxt == NB_WORD_IDX'(N_WORDS)) ? ST_DONE : ST_LOAD;
               end else begin
                  byte_idx_nxt = byte_idx + NB_BYTE_IDX'(1);
                  state_nxt    = ST_SEND;
               end
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase

      // Address is launched as LOAD is entered so the 1-cycle read data is
      // already valid when FETCH ends and captures it.
      load_src = word_src(32'(word_idx_nxt), N_REGISTERS);
      if (state_nxt == ST_LOAD) begin
         case (load_src)
            SRC_REG: reg_addr_nxt = NB_REGISTER'(32'(word_idx_nxt) - N_FIXED_WORDS);
            SRC_MEM: mem_addr_nxt = NB_MEM_ADDR'(32'(word_idx_nxt) - MEM_BASE);
            default: ;
         endcase
      end

      busy_nxt = (state_nxt != ST_IDLE) && (state_nxt != ST_DONE);
      done_nxt = (state_nxt == ST_DONE);
   end

endmodule

// File: tb/tb_du_report_tx.sv
// Directed bench for du_report_tx: full 200-byte dump with modelled register
// and memory contents, start filtering, async reset mid-frame, tick stall,
// and slow-tick bit timing. A UART decoder rebuilds the byte stream.
module tb_du_report_tx;

   localparam int SB = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        tick = 1'b0;
   logic        start;
   logic [31:0] pc, cycles;
   logic [4:0]  reg_addr;
   logic [31:0] reg_data = '0;
   logic [3:0]  mem_addr;
   logic [31:0] mem_data = '0;
   logic        tx, busy, done;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;

   // decoder / tick generator state
   logic [7:0] q[$];
   int         falls[$];
   bit         mon_on = 1'b0;
   int         mon_cnt, mon_k;
   logic [7:0] mon_sh;
   int         frame_err = 0;
   int         done_cnt = 0;
   int         tick_div = 1;
   bit         tick_hold = 1'b0;
   int         tick_ph = 0;

   du_report_tx u_dut (
      .i_clk      (clk),
      .i_reset    (rst_n),
      .i_tick     (tick),
      .i_start    (start),
      .i_pc       (pc),
      .i_cycles   (cycles),
      .o_reg_addr (reg_addr),
      .i_reg_data (reg_data),
      .o_mem_addr (mem_addr),
      .i_mem_data (mem_data),
      .o_tx       (tx),
      .o_busy     (busy),
      .o_done     (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous 1-cycle-latency register file and memory models
   always @(posedge clk) begin
      reg_data <= (reg_addr == 5'd5) ? 32'hB0B0B0B0 : {27'd0, reg_addr};
      mem_data <= (mem_addr == 4'd2) ? 32'h00110011 : {28'hC0DE000, mem_addr};
   end

   // UART decoder (samples mid-bit by counting ticks), done counter, tick generator
   always @(negedge clk) begin
      if (!rst_n) begin
         mon_on = 1'b0;
      end else if (!mon_on) begin
         if (tx === 1'b0) begin
            mon_on = 1'b1; mon_cnt = 0; mon_sh = '0;
            falls.push_back(cyc);
         end
      end else if (tick) begin
         mon_cnt++;
         if (mon_cnt % SB == SB / 2) begin
            mon_k = mon_cnt / SB;
            if (mon_k == 0) begin
               if (tx !== 1'b0) frame_err++;
            end else if (mon_k <= 8) begin
               mon_sh[mon_k-1] = tx;
            end else begin
               if (tx !== 1'b1) frame_err++;
               q.push_back(mon_sh);
               mon_on = 1'b0;
            end
         end
      end
      if (done === 1'b1) done_cnt++;

      if (tick_hold) tick = 1'b0;
      else if (tick_div <= 1) tick = 1'b1;
      else if (tick_ph >= tick_div - 1) begin tick = 1'b1; tick_ph = 0; end
      else begin tick = 1'b0; tick_ph++; end
   end

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] exp_word(input int j);
      if (j == 0) return 32'hAABBCCDD;
      if (j == 1) return 32'h44444444;
      if (j < 34) return (j - 2 == 5) ? 32'hB0B0B0B0 : 32'(j - 2);
      return (j - 34 == 2) ? 32'h00110011 : (32'hC0DE0000 | 32'(j - 34));
   endfunction

   function automatic logic [7:0] exp_byte(input int i);
      logic [31:0] w;
      w = exp_word(i / 4) >> (8 * (3 - (i % 4)));
      return w[7:0];
   endfunction

   task automatic wait_tx(input logic lvl, input int budget, input string tag);
      int n = 0;
      while (tx !== lvl && n < budget) begin @(negedge clk); n++; end
      check_vec(tag, 32'(tx), 32'(lvl));
   endtask

   task automatic wait_bytes(input int nb, input int budget, input string tag);
      int n = 0;
      while (q.size() < nb && n < budget) begin @(negedge clk); n++; end
      check_vec(tag, 32'(q.size() >= nb), 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int n, t0, changes, lows;
      logic lvl;
      logic [7:0] got;

      rst_n = 1'b0; start = 1'b0; pc = '0; cycles = '0;
      repeat (3) @(negedge clk);
      check_vec("rst_tx", 32'(tx), 32'd1);
      check_vec("rst_busy", 32'(busy), 32'd0);
      check_vec("rst_done", 32'(done), 32'd0);
      check_vec("rst_reg_addr", 32'(reg_addr), 32'd0);
      check_vec("rst_mem_addr", 32'(mem_addr), 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Full dump, snapshot isolation, mid-dump start ignored
      q.delete(); falls.delete(); done_cnt = 0; frame_err = 0;
      pc = 32'hAABBCCDD; cycles = 32'h44444444;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0; pc = 32'h12345678;
      check_vec("busy_after_start", 32'(busy), 32'd1);
      n = 0;
      while (tx !== 1'b0 && n < 10) begin @(negedge clk); n++; end
      check_vec("start_latency", 32'(n >= 1 && n <= 3), 32'd1);
      repeat (5000) @(negedge clk);
      check_vec("busy_mid", 32'(busy), 32'd1);
      pulse_start();
      repeat (3) @(negedge clk);
      check_vec("busy_after_2nd_start", 32'(busy), 32'd1);
      n = 0;
      while (done !== 1'b1 && n < 40000) begin @(negedge clk); n++; end
      check_vec("done_seen", 32'(done), 32'd1);
      start = 1'b1;                   // sampled while in DONE: must be ignored
      check_vec("busy_in_done", 32'(busy), 32'd0);
      @(negedge clk);
      start = 1'b0;
      check_vec("done_width", 32'(done), 32'd0);
      repeat (400) @(negedge clk);
      check_vec("busy_after_done", 32'(busy), 32'd0);
      check_vec("tx_idle_after", 32'(tx), 32'd1);
      check_vec("done_count", 32'(done_cnt), 32'd1);
      check_vec("byte_count", 32'(q.size()), 32'd200);
      check_vec("frame_err_a", 32'(frame_err), 32'd0);
      n = (falls.size() >= 2) ? falls[1] - falls[0] : 0;
      check_vec("byte_period", 32'(n >= 160 && n <= 163), 32'd1);
      for (int i = 0; i < 200; i++) begin
         got = (i < q.size()) ? q[i] : 8'hxx;
         check_vec($sformatf("byte%0d", i), 32'(got), 32'(exp_byte(i)));
      end

      // Async reset during data bits of byte 10, then restart from PC
      q.delete(); falls.delete(); frame_err = 0;
      pc = 32'hAABBCCDD;
      pulse_start();
      wait_bytes(10, 3000, "reach_byte10");
      wait_tx(1'b0, 200, "byte10_start");
      repeat (48) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_vec("rst_mid_tx", 32'(tx), 32'd1);
      check_vec("rst_mid_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      q.delete(); falls.delete();
      repeat (2) @(negedge clk);
      check_vec("tx_after_rst", 32'(tx), 32'd1);

      // Restarted dump with a 1000-cycle tick stall inside byte 2
      pulse_start();
      wait_bytes(2, 1000, "reach_byte2");
      wait_tx(1'b0, 100, "byte2_start");
      repeat (50) @(negedge clk);
      tick_hold = 1'b1;
      repeat (2) @(negedge clk);
      lvl = tx; changes = 0;
      repeat (1000) begin
         @(negedge clk);
         if (tx !== lvl) changes++;
      end
      check_vec("stall_hold", 32'(changes), 32'd0);
      check_vec("stall_busy", 32'(busy), 32'd1);
      tick_hold = 1'b0;
      wait_bytes(8, 2000, "reach_byte8");
      for (int i = 0; i < 8; i++) begin
         got = (i < q.size()) ? q[i] : 8'hxx;
         check_vec($sformatf("restart_byte%0d", i), 32'(got), 32'(exp_byte(i)));
      end
      check_vec("frame_err_b", 32'(frame_err), 32'd0);

      // Slow tick: one tick per 651 cycles; line idles high, start bit = 16 ticks
      rst_n = 1'b0;
      @(negedge clk);
      tick_div = 651;
      rst_n = 1'b1;
      pc = 32'h55667788;             // first data bit is 1, so the start bit ends on a rising edge
      lows = 0;
      repeat (2000) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
      check_vec("idle_high", 32'(lows), 32'd0);
      pulse_start();
      wait_tx(1'b0, 2000, "slow_start_bit");
      t0 = cyc;
      wait_tx(1'b1, 20000, "slow_bit0");
      n = cyc - t0;
      check_vec("bit_period", 32'(n >= 16 * 651 - 1 && n <= 16 * 651 + 1), 32'd1);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
